sender_arbiter: RTL and testbench
=================================

Name: sender_arbiter

Overview:
Round-robin scheduler that shares one valid/ready sender channel among NREQ requesters in the Bridge datapath. It picks one pending requester, latches its word and presents it downstream with valid until ready is seen. It then reports completion to the winner. A watchdog aborts any transfer the receiver never accepts, so a dead sink cannot lock the channel.

Parameters:
WIDTH, 8, data word width (matches the `WIDTH define used by the sender datapath)
NREQ, 4, number of requesters; legal range 1..16
TIMEOUT, 16, max cycles valid may wait for ready before abort; legal range 1..255

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request level; bit i held high until gnt[i]
data_in  input  NREQ*WIDTH  requester words; slice i = data_in[i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot one-cycle pulse: word of requester i latched
done  output  NREQ  one-hot one-cycle pulse: word of requester i accepted downstream
data_out  output  WIDTH  word presented to sink
valid  output  1  data_out valid
ready  input  1  sink accepts when valid & ready at posedge
busy  output  1  high whenever state != IDLE
timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst low, async): state=IDLE, ptr=0, wait_cnt=0. Outputs: gnt=0, done=0, data_out=0, valid=0, busy=0, timeout_err=0. Reset mid-transfer drops the word; there is no done or timeout_err for it.
- States: IDLE, SEND.
- IDLE, req==0: hold.
- IDLE, req!=0:
  - Winner = first set bit searching ptr, ptr+1, ... wrapping mod NREQ.
  - At that edge: latch winner index and its data_in slice into data_out. Pulse gnt[winner] for the following cycle. Go to SEND; valid=1 from the next cycle.
- Latency: req sampled high -> valid high 1 cycle later.
- SEND: valid=1 and data_out held stable. Each cycle with ready=0, wait_cnt increments.
- SEND, valid&ready at posedge:
  - Transfer completes. Pulse done[winner] next cycle.
  - ptr = (winner+1) mod NREQ; wait_cnt=0; go to IDLE; valid=0 next cycle.
- SEND, ready=0 with wait_cnt==TIMEOUT-1 at posedge:
  - Abort. Pulse timeout_err next cycle; no done.
  - ptr = (winner+1) mod NREQ; wait_cnt=0; go to IDLE; valid=0.
  - valid is therefore high for exactly TIMEOUT cycles on abort.
- A ready arriving on the timeout cycle wins: transfer completes, no error.
- Throughput: at most one word per 2 cycles (SEND, IDLE); valid always drops for ≥1 cycle between words.
- ready while valid=0 is ignored.
- req changes during SEND have no effect until IDLE. A requester that drops req before being granted is skipped.
- After gnt[i], requester i may drop or change req[i] and its data_in slice freely; the latched word is unaffected. If it keeps req high, it re-competes after all other pending requesters (fairness).
- NREQ=1: always grants bit 0; ptr stays 0.
- gnt, done and timeout_err are never asserted in the same cycle for different requesters. gnt and done are one-hot or zero.
- wait_cnt width: $clog2(TIMEOUT+1).

Test Plan:
- Single request: req=4'b0100, data_in slice2=8'hA5, ready tied 1. Required: gnt=4'b0100 one cycle; valid high 1 cycle with data_out=8'hA5; done=4'b0100 next cycle; busy low again after.
- Contention: req=4'b1111 held, distinct words 8'h10..8'h13, ready=1, ptr=0 after reset. Required: grants in order 0,1,2,3,0; valid pulses every 2nd cycle; data_out matches each winner.
- Stall: one request, ready low 5 cycles then high. Required: valid high 6 cycles; data_out constant; done once; no timeout_err.
- Timeout: req=4'b0001, ready held 0, TIMEOUT=16. Required: valid high exactly 16 cycles; timeout_err pulses; no done; next grant searches from bit 1.
- Reset mid-SEND: rst driven low asynchronously while valid=1. Required: valid, busy and data_out go to 0 immediately without a clock edge; no done or timeout_err; first grant after release goes to bit 0.
- Ready-on-timeout-cycle: ready rises exactly on cycle 16 of waiting. Required: done pulses; timeout_err stays 0.

Source files
------------

// File: rtl/sender_arbiter.sv
// Round-robin sharing of one valid/ready sender channel among NREQ requesters,
// with a watchdog that aborts transfers the sink never accepts.

module sender_arbiter_checker #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input logic             clk,
   input logic             rst,
   input logic [NREQ-1:0]  gnt,
   input logic [NREQ-1:0]  done,
   input logic [WIDTH-1:0] data_out,
   input logic             valid,
   input logic             ready,
   input logic             busy,
   input logic             timeout_err
);

   a_gnt_onehot:  assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
   a_done_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(done));
   a_gnt_done:    assert property (@(posedge clk) disable iff (!rst) !((|gnt) && (|done)));
   a_gnt_err:     assert property (@(posedge clk) disable iff (!rst) !((|gnt) && timeout_err));
   a_done_err:    assert property (@(posedge clk) disable iff (!rst) !((|done) && timeout_err));
   a_busy_valid:  assert property (@(posedge clk) disable iff (!rst) (valid == busy));
   a_gnt_valid:   assert property (@(posedge clk) disable iff (!rst) (|gnt) |-> valid);
   a_done_idle:   assert property (@(posedge clk) disable iff (!rst) (|done) |-> !valid);
   a_err_idle:    assert property (@(posedge clk) disable iff (!rst) timeout_err |-> !valid);
   // Word must not move while the sink is still being offered it.
   a_stable:      assert property (@(posedge clk) disable iff (!rst)
                                   (valid && $past(valid)) |-> $stable(data_out));

endmodule

module sender_arbiter #(
   parameter int WIDTH   = 8,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] data_in,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic [WIDTH-1:0]      data_out,
   output logic                  valid,
   input  logic                  ready,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t            state_r, state_s;
   logic [PW-1:0]     ptr_r, ptr_s;
   logic [PW-1:0]     win_r, win_s;
   logic [PW-1:0]     pick_s;
   logic [CW-1:0]     wait_r, wait_s;
   logic [NREQ-1:0]   gnt_s, done_s;
   logic              err_s;
   logic              valid_s;
   logic [WIDTH-1:0]  data_s;

   // First set request bit searching upward from p, wrapping mod NREQ.
   function automatic logic [PW-1:0] pick_winner(input logic [NREQ-1:0] r,
                                                 input logic [PW-1:0]   p);
      logic [PW-1:0] w;
      logic          found;
      int            idx;
      w     = p;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(p) + k) % NREQ;
         if (!found && r[idx]) begin
            w     = PW'(idx);
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return w;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
      logic [NREQ-1:0] o;
      for (int k = 0; k < NREQ; k++) begin
         o[k] = (i == PW'(k));
      end
      return o;
   endfunction

   function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
      return PW'((int'(i) + 1) % NREQ);
   endfunction

   assign pick_s = pick_winner(req, ptr_r);

   // Next-state and next-output decode.
   always_comb begin
      state_s = state_r;
      ptr_s   = ptr_r;
      win_s   = win_r;
      wait_s  = wait_r;
      gnt_s   = {NREQ{1'b0}};
      done_s  = {NREQ{1'b0}};
      err_s   = 1'b0;
      valid_s = valid;
      data_s  = data_out;
      case (state_r)
         IDLE: begin
            if (req != {NREQ{1'b0}}) begin
               win_s   = pick_s;
               data_s  = data_in[int'(pick_s)*WIDTH +: WIDTH];
               gnt_s   = onehot(pick_s);
               valid_s = 1'b1;
               state_s = SEND;
            end else begin
               state_s = IDLE;
            end
         end
         SEND: begin
            // A ready on the final watchdog cycle still completes the transfer.
            if (ready) begin
               done_s  = onehot(win_r);
               ptr_s   = next_idx(win_r);
               wait_s  = {CW{1'b0}};
               valid_s = 1'b0;
               state_s = IDLE;
            end else if (wait_r == CW'(TIMEOUT - 1)) begin
               err_s   = 1'b1;
               ptr_s   = next_idx(win_r);
               wait_s  = {CW{1'b0}};
               valid_s = 1'b0;
               state_s = IDLE;
            end else begin
               wait_s  = wait_r + CW'(1);
            end
         end
         default: begin
            wait_s  = {CW{1'b0}};
            valid_s = 1'b0;
            state_s = IDLE;
         end
      endcase
   end

   // State and registered outputs; async reset drops any in-flight word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         ptr_r       <= {PW{1'b0}};
         win_r       <= {PW{1'b0}};
         wait_r      <= {CW{1'b0}};
         gnt         <= {NREQ{1'b0}};
         done        <= {NREQ{1'b0}};
         data_out    <= {WIDTH{1'b0}};
         valid       <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state_r     <= state_s;
         ptr_r       <= ptr_s;
         win_r       <= win_s;
         wait_r      <= wait_s;
         gnt         <= gnt_s;
         done        <= done_s;
         data_out    <= data_s;
         valid       <= valid_s;
         busy        <= (state_s != IDLE);
         timeout_err <= err_s;
      end
   end

   sender_arbiter_checker #(
      .WIDTH (WIDTH),
      .NREQ  (NREQ)
   ) u_checker (
      .clk         (clk),
      .rst         (rst),
      .gnt         (gnt),
      .done        (done),
      .data_out    (data_out),
      .valid       (valid),
      .ready       (ready),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

endmodule

// File: tb/tb_sender_arbiter.sv
// Randomised and directed bench for sender_arbiter against a transaction-level model.

module tb_sender_arbiter;

   localparam int WIDTH   = 8;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] data_in;
   logic [NREQ-1:0]       gnt, done;
   logic [WIDTH-1:0]      data_out;
   logic                  valid, ready, busy, timeout_err;

   int vectors     = 0;
   int miscompares = 0;

   // reference model: is a word in flight, whose, how many valid cycles so far, where to search next
   bit               m_sending;
   int               m_cur, m_age, m_ptr;
   logic [NREQ-1:0]  exp_gnt, exp_done;
   logic             exp_valid, exp_busy, exp_err;
   logic [WIDTH-1:0] exp_data;

   sender_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .data_in(data_in), .gnt(gnt), .done(done),
      .data_out(data_out), .valid(valid), .ready(ready), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_sending = 1'b0; m_cur = 0; m_age = 0; m_ptr = 0;
      exp_gnt = '0; exp_done = '0; exp_valid = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
      exp_data = '0;
   endtask

   // Effect of one rising edge with the given inputs, expressed as transfer rules.
   task automatic model_advance(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d,
                                input logic rd);
      bit found;
      exp_gnt = '0; exp_done = '0; exp_err = 1'b0;
      if (!m_sending) begin
         if (r != '0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
               if (!found && r[(m_ptr + k) % NREQ]) begin
                  m_cur = (m_ptr + k) % NREQ;
                  found = 1'b1;
               end
            end
            exp_gnt[m_cur] = 1'b1;
            exp_data = d[m_cur*WIDTH +: WIDTH];
            m_sending = 1'b1;
            m_age = 1;
         end
      end else if (rd) begin
         exp_done[m_cur] = 1'b1;
         m_sending = 1'b0;
         m_ptr = (m_cur + 1) % NREQ;
      end else if (m_age == TIMEOUT) begin
         exp_err = 1'b1;
         m_sending = 1'b0;
         m_ptr = (m_cur + 1) % NREQ;
      end else begin
         m_age++;
      end
      exp_valid = m_sending;
      exp_busy  = m_sending;
   endtask

   // Called at a falling edge: apply inputs, advance the model, move to the next falling edge.
   task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d, input logic rd);
      req = r; data_in = d; ready = rd;
      model_advance(r, d, rd);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0; req = '0; data_in = '0; ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b0; req = '0; data_in = '0; ready = 1'b0;
      #1;
      vectors++;
      if ({gnt, done, valid, busy, timeout_err, data_out} !== 19'h0) begin
         miscompares++;
         $display("FAIL reset: got %h required 0", {gnt, done, valid, busy, timeout_err, data_out});
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      logic [NREQ*WIDTH-1:0] d;
      do_reset();
      d = '0;
      d[2*WIDTH +: WIDTH] = 8'hA5;
      for (int i = 0; i < 4; i++) begin
         step((i == 0) ? 4'b0100 : 4'b0000, d, 1'b1);
         vectors++;
         if ({gnt, done, valid, busy, timeout_err, data_out} !==
             {exp_gnt, exp_done, exp_valid, exp_busy, exp_err, exp_data}) begin
            miscompares++;
            $display("FAIL single cyc%0d: got %h required %h", i,
                     {gnt, done, valid, busy, timeout_err, data_out},
                     {exp_gnt, exp_done, exp_valid, exp_busy, exp_err, exp_data});
         end
         vectors++;
         if ((i == 0 && {gnt, valid, data_out} !== {4'b0100, 1'b1, 8'hA5}) ||
             (i == 1 && {done, valid} !== {4'b0100, 1'b0}) ||
             (i == 3 && busy !== 1'b0)) begin
            miscompares++;
            $display("FAIL single_fixed cyc%0d: got gnt=%b done=%b valid=%b busy=%b data=%h",
                     i, gnt, done, valid, busy, data_out);
         end
      end
   endtask

   task automatic test_contention();
      int order[$];
      int exp_order[5] = '{0, 1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10}, 1'b1);
         for (int b = 0; b < NREQ; b++) if (gnt[b]) order.push_back(b);
         vectors++;
         if ({gnt, done, valid, busy, timeout_err, data_out} !==
             {exp_gnt, exp_done, exp_valid, exp_busy, exp_err, exp_data}) begin
            miscompares++;
            $display("FAIL contention cyc%0d: got %h required %h", i,
                     {gnt, done, valid, busy, timeout_err, data_out},
                     {exp_gnt, exp_done, exp_valid, exp_busy, exp_err, exp_data});
         end
      end
      vectors++;
      if (order.size() != 5) begin
         miscompares++;
         $display("FAIL contention_count: got %0d grants required 5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (order[i] != exp_order[i]) begin
               miscompares++;
               $display("FAIL contention_order[%0d]: got %0d required %0d", i, order[i], exp_order[i]);
            end
         end
      end
   endtask

   task automatic test_stall();
      int vcnt = 0, dcnt = 0, ecnt = 0;
      logic [NREQ*WIDTH-1:0] d;
      do_reset();
      d = $urandom;
      for (int i = 0; i < 8; i++) begin
         step((i == 0) ? 4'b0001 : 4'b0000, d, (i == 6));
         vcnt += valid; dcnt += (done != '0); ecnt += timeout_err;
         vectors++;
         if ({gnt, done, valid, busy, timeout_err, data_out} !==
             {exp_gnt, exp_done, exp_valid, exp_busy, exp_err, exp_data}) begin
            miscompares++;
            $display("FAIL stall cyc%0d: got %h required %h", i,
                     {gnt, done, valid, busy, timeout_err, data_out},
                     {exp_gnt, exp_done, exp_valid, exp_busy, exp_err, exp_data});
         end
      end
      vectors++;
      if (vcnt != 6 || dcnt != 1 || ecnt != 0) begin
         miscompares++;
         $display("FAIL stall_counts: got valid=%0d done=%0d err=%0d required 6 1 0", vcnt, dcnt, ecnt);
      end
   endtask

   task automatic test_timeout();
      int vcnt = 0, dcnt = 0, ecnt = 0;
      logic [NREQ*WIDTH-1:0] d;
      do_reset();
      d = $urandom;
      for (int i = 0; i < 21; i++) begin
         step((i == 0) ? 4'b0001 : 4'b0000, d, 1'b0);
         vcnt += valid; dcnt += (done != '0); ecnt += timeout_err;
         vectors++;
         if ({gnt, done, valid, busy, timeout_err, data_out} !==
             {exp_gnt, exp_done, exp_valid, exp_busy, exp_err, exp_data}) begin
            miscompares++;
            $display("FAIL timeout cyc%0d: got %h required %h", i,
                     {gnt, done, valid, busy, timeout_err, data_out},
                     {exp_gnt, exp_done, exp_valid, exp_busy, exp_err, exp_data});
         end
      end
      vectors++;
      if (vcnt != TIMEOUT || dcnt != 0 || ecnt != 1) begin
         miscompares++;
         $display("FAIL timeout_counts: got valid=%0d done=%0d err=%0d required 16 0 1", vcnt, dcnt, ecnt);
      end
      step(4'b0011, d, 1'b1);
      vectors++;
      if (gnt !== 4'b0010) begin
         miscompares++;
         $display("FAIL timeout_next_grant: got %b required 0010", gnt);
      end
      step(4'b0000, d, 1'b1);
   endtask

   task automatic test_ready_on_timeout();
      logic [NREQ*WIDTH-1:0] d;
      do_reset();
      d = $urandom;
      for (int i = 0; i < 18; i++) begin
         step((i == 0) ? 4'b0001 : 4'b0000, d, (i == 16));
         vectors++;
         if ({gnt, done, valid, busy, timeout_err, data_out} !==
             {exp_gnt, exp_done, exp_valid, exp_busy, exp_err, exp_data}) begin
            miscompares++;
            $display("FAIL ready_on_timeout cyc%0d: got %h required %h", i,
                     {gnt, done, valid, busy, timeout_err, data_out},
                     {exp_gnt, exp_done, exp_valid, exp_busy, exp_err, exp_data});
         end
         vectors++;
         if (timeout_err !== 1'b0 || (i == 16 && done !== 4'b0001)) begin
            miscompares++;
            $display("FAIL ready_on_timeout_fixed cyc%0d: got done=%b err=%b", i, done, timeout_err);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [NREQ*WIDTH-1:0] d;
      do_reset();
      d = $urandom;
      d[2*WIDTH +: WIDTH] = 8'h5A;
      step(4'b0100, d, 1'b0);
      step(4'b0000, d, 1'b0);
      #2 rst = 1'b0;
      #1;
      vectors++;
      if ({gnt, done, valid, busy, timeout_err, data_out} !== 19'h0) begin
         miscompares++;
         $display("FAIL async_reset: got %h required 0", {gnt, done, valid, busy, timeout_err, data_out});
      end
      @(negedge clk);
      vectors++;
      if ({done, timeout_err} !== 5'h0) begin
         miscompares++;
         $display("FAIL async_reset_hold: got done=%b err=%b required 0", done, timeout_err);
      end
      rst = 1'b1;
      model_reset();
      step(4'b1111, d, 1'b1);
      vectors++;
      if (gnt !== 4'b0001) begin
         miscompares++;
         $display("FAIL async_reset_first_grant: got %b required 0001", gnt);
      end
      step(4'b0000, d, 1'b1);
   endtask

   task automatic test_random();
      logic rd;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (((i / 100) % 2) == 1) rd = ($urandom_range(0, 15) == 0);
         else                      rd = ($urandom_range(0, 1) == 0);
         step(NREQ'($urandom), $urandom, rd);
         vectors++;
         if ({gnt, done, valid, busy, timeout_err, data_out} !==
             {exp_gnt, exp_done, exp_valid, exp_busy, exp_err, exp_data}) begin
            miscompares++;
            $display("FAIL random cyc%0d: got %h required %h", i,
                     {gnt, done, valid, busy, timeout_err, data_out},
                     {exp_gnt, exp_done, exp_valid, exp_busy, exp_err, exp_data});
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_stall();
      test_timeout();
      test_ready_on_timeout();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
